shot_validator: RTL
===================

SHOT_VALIDATOR -- requirements
Module: shot_validator

Interface
REQ-001 Parameter BOARD_W, default 10: number of board cells; width of every cell vector.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: stable-sample count required to accept a fire-button level change.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 clr_n  input  1  reset, synchronous, active-low.
REQ-005 sw  input  BOARD_W  raw target switches from the attacking player.
REQ-006 fire_btn  input  1  raw, asynchronous fire pushbutton.
REQ-007 arm  input  1  high while the game FSM is in this player's attack phase.
REQ-008 attack  output  BOARD_W  last accepted one-hot shot; feeds the attack register downstream.
REQ-009 history  output  BOARD_W  OR of all accepted shots since reset.
REQ-010 ok  output  1  one-cycle pulse: shot accepted.
REQ-011 err  output  1  one-cycle pulse: shot rejected.
REQ-012 shots  output  $clog2(BOARD_W+1)  accepted-shot count.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 fire_btn SHALL pass through a 2-flop synchronizer before any use.
REQ-015 A fire event SHALL be a 0->1 transition of the conditioned button level.
REQ-016 FSM states SHALL be IDLE, CHECK, RESULT, WAIT_RELEASE.
REQ-017 IDLE->CHECK on a fire event with arm=1; fire events with arm=0 SHALL be ignored.
REQ-018 CHECK SHALL register sw and compute valid = (popcount(sw)==1) AND ((sw & ~history)!=0).
REQ-019 CHECK->RESULT unconditionally if arm=1; if arm=0, CHECK->WAIT_RELEASE with no pulse and no state update.
REQ-020 In RESULT, if valid: attack<=registered sw, history<=history|sw, shots<=shots+1, ok=1 for exactly one cycle.
REQ-021 In RESULT, if not valid: err=1 for exactly one cycle; attack, history and shots SHALL be unchanged.
REQ-022 RESULT->WAIT_RELEASE unconditionally; WAIT_RELEASE->IDLE when the conditioned button level is 0.
REQ-023 ok/err SHALL assert exactly 2 clk cycles after the cycle the fire event is detected; never both in the same cycle.
REQ-024 shots SHALL saturate at BOARD_W; when history is all ones, every shot is rejected with err.
REQ-025 sw changes outside CHECK SHALL have no effect.

Reset
REQ-026 clr_n=0 at a clock edge SHALL force state IDLE, attack=0, history=0, shots=0, ok=0, err=0, busy=0, synchronizer and debounce state to 0, in any state including mid-CHECK/RESULT; no pending pulse survives reset.

Configuration
REQ-027 Macro SHOT_VALIDATOR_DEBOUNCE_EN defined: conditioned level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-028 Macro undefined: conditioned level equals the synchronized input; DEBOUNCE_CYCLES unused; all other behaviour identical.

Structure
REQ-029 battleship_pkg SHALL hold BOARD_W default constant and the validator state enum typedef.
REQ-030 Synchronizer plus debounce SHALL be one sub-module, btn_conditioner, instanced once.

Verification (BOARD_W=10, DEBOUNCE_CYCLES=4, macro defined unless stated)
REQ-031 Reset, arm=1, sw=10'b0000000100, press held 10 cycles -> ok pulse, attack=0x004, history=0x004, shots=1.
REQ-032 Repeat sw=0x004 after release/re-press -> err pulse, history=0x004, shots=1; then sw=0x006 -> err (two bits), sw=0x000 -> err.
REQ-033 Glitch fire_btn high 2 cycles -> no busy, no pulse; macro undefined, same glitch -> accepted shot.
REQ-034 Fire ten distinct one-hot values -> shots=10, history=0x3FF; eleventh press any sw -> err, shots stays 10.
REQ-035 Drop arm in CHECK cycle -> no ok/err, history unchanged; clr_n=0 in RESULT cycle -> no pulse, all outputs 0 next cycle.
REQ-036 Hold button 50 cycles -> exactly one ok; second shot requires release then re-press.

Source files
------------

// File: rtl/battleship_pkg.sv
// battleship_pkg: shared constants and types for the battleship shot path.
//   BOARD_W_DEF  : default number of board cells
//   val_state_e  : shot validator FSM state encoding
package battleship_pkg;

   localparam int unsigned BOARD_W_DEF = 10;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      RESULT,
      WAIT_RELEASE
   } val_state_e;

endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: brings the asynchronous fire pushbutton into the clk
// domain through a two-flop synchronizer, then optionally debounces it.
//   clk      in   system clock
//   clr_n    in   synchronous active-low clear
//   btn_i    in   raw asynchronous button level
//   level_o  out  conditioned button level
// Configuration: define SHOT_VALIDATOR_DEBOUNCE_EN to enable the debounce
// filter (level changes only after DEBOUNCE_CYCLES consecutive disagreeing
// samples); otherwise level_o is the synchronizer output.
module btn_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic clr_n,
   input  logic btn_i,
   output logic level_o
);

   logic meta_q;
   logic sync_q;

   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples the values from before the clock edge.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= btn_i;
         sync_q <= meta_q;
      end
   end

`ifdef SHOT_VALIDATOR_DEBOUNCE_EN
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             level_q;
   logic             level_d;

   // The counter holds how many consecutive cycles the synchronized input has
   // disagreed with the accepted level; any agreeing cycle restarts it, so
   // short glitches never reach the output.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level_o = level_q;
`else
   assign level_o = sync_q;
`endif

endmodule

// File: rtl/shot_validator.sv
// shot_validator: accepts one shot per fire-button press during the attack
// phase, checks that the switches select exactly one not-yet-fired cell, and
// records accepted shots.
//   clk       in   system clock
//   clr_n     in   synchronous active-low reset
//   sw        in   target switches (sampled only in CHECK)
//   fire_btn  in   raw asynchronous fire pushbutton
//   arm       in   high during this player's attack phase
//   attack    out  last accepted one-hot shot
//   history   out  OR of all accepted shots since reset
//   ok        out  one-cycle pulse, shot accepted
//   err       out  one-cycle pulse, shot rejected
//   shots     out  accepted-shot count, saturating at BOARD_W
//   busy      out  high whenever the FSM is not in IDLE
// Configuration: SHOT_VALIDATOR_DEBOUNCE_EN enables button debouncing in
// btn_conditioner; without it DEBOUNCE_CYCLES has no effect.
module shot_validator
   import battleship_pkg::*;
#(
   parameter int unsigned BOARD_W         = BOARD_W_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic                         clk,
   input  logic                         clr_n,
   input  logic [BOARD_W-1:0]           sw,
   input  logic                         fire_btn,
   input  logic                         arm,
   output logic [BOARD_W-1:0]           attack,
   output logic [BOARD_W-1:0]           history,
   output logic                         ok,
   output logic                         err,
   output logic [$clog2(BOARD_W+1)-1:0] shots,
   output logic                         busy
);

   localparam int unsigned SHOTS_W = $clog2(BOARD_W + 1);
   localparam logic [SHOTS_W-1:0] SHOTS_MAX = SHOTS_W'(BOARD_W);

   val_state_e state_q, state_d;

   logic               btn_level;
   logic               level_prev_q;
   logic               fire_evt;
   logic               sw_one_hot;
   logic               sw_valid;
   logic [BOARD_W-1:0] sw_q, sw_d;
   logic               valid_q, valid_d;
   logic [BOARD_W-1:0] attack_q, attack_d;
   logic [BOARD_W-1:0] history_q, history_d;
   logic [SHOTS_W-1:0] shots_q, shots_d;

   btn_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_conditioner (
      .clk     (clk),
      .clr_n   (clr_n),
      .btn_i   (fire_btn),
      .level_o (btn_level)
   );

   assign fire_evt = btn_level & ~level_prev_q;

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   assign sw_one_hot = (sw != '0) && ((sw & (sw - BOARD_W'(1))) == '0);
   assign sw_valid   = sw_one_hot && ((sw & ~history_q) != '0);

   // State register
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: every combinational output gets a default before the case so no
      // path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      case (state_q)
         IDLE:         if (fire_evt && arm) state_d = CHECK;
         CHECK:        state_d = arm ? RESULT : WAIT_RELEASE;
         RESULT:       state_d = WAIT_RELEASE;
         WAIT_RELEASE: if (!btn_level) state_d = IDLE;
         default:      state_d = IDLE;
      endcase
   end

   // Outputs; the clr_n term keeps a pulse in flight from showing while
   // reset is being applied.
   always_comb begin
      busy = (state_q != IDLE);
      ok   = clr_n && (state_q == RESULT) && valid_q;
      err  = clr_n && (state_q == RESULT) && !valid_q;
   end

   // Datapath next-state: capture in CHECK, commit in RESULT when valid.
   always_comb begin
      sw_d      = sw_q;
      valid_d   = valid_q;
      attack_d  = attack_q;
      history_d = history_q;
      shots_d   = shots_q;
      if (state_q == CHECK) begin
         sw_d    = sw;
         valid_d = sw_valid;
      end
      if ((state_q == RESULT) && valid_q) begin
         attack_d  = sw_q;
         history_d = history_q | sw_q;
         if (shots_q != SHOTS_MAX) begin
            shots_d = shots_q + SHOTS_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         level_prev_q <= 1'b0;
         sw_q         <= '0;
         valid_q      <= 1'b0;
         attack_q     <= '0;
         history_q    <= '0;
         shots_q      <= '0;
      end else begin
         level_prev_q <= btn_level;
         sw_q         <= sw_d;
         valid_q      <= valid_d;
         attack_q     <= attack_d;
         history_q    <= history_d;
         shots_q      <= shots_d;
      end
   end

   assign attack  = attack_q;
   assign history = history_q;
   assign shots   = shots_q;

endmodule
